// File: rtl/vecmac_pkg.sv
// Shared types and sizing for the int8 vector-MAC sequencer.
package vecmac_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int PROD_W = 2 * LANE_W;
    // Four 16-bit lane products sum to at most 4*0xFE01, which needs 18 bits.
    localparam int SUM_W  = PROD_W + 2;

    localparam int DEFAULT_LEN_W = 8;
    localparam int DEFAULT_ACC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/vecmac_if.sv
// Command, operand, multiplier and result channels of the vector-MAC sequencer.
interface vecmac_if
    import vecmac_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W,
    parameter int ACC_W = DEFAULT_ACC_W
);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [LEN_W-1:0]        cmd_len;

    logic                    op_valid;
    logic                    op_ready;
    logic [LANES*LANE_W-1:0] op_a;
    logic [LANES*LANE_W-1:0] op_b;

    logic                    mul_in_valid;
    logic [LANES*LANE_W-1:0] mul_in_a;
    logic [LANES*LANE_W-1:0] mul_in_b;
    logic                    mul_out_valid;
    logic [LANES*PROD_W-1:0] mul_product;

    logic                    res_valid;
    logic                    res_ready;
    logic [ACC_W-1:0]        res_data;

    logic                    busy;

    modport master (
        output cmd_valid, cmd_len, op_valid, op_a, op_b,
               mul_out_valid, mul_product, res_ready,
        input  cmd_ready, op_ready, mul_in_valid, mul_in_a, mul_in_b,
               res_valid, res_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_len, op_valid, op_a, op_b,
               mul_out_valid, mul_product, res_ready,
        output cmd_ready, op_ready, mul_in_valid, mul_in_a, mul_in_b,
               res_valid, res_data, busy
    );

endinterface

// File: rtl/vecmac_lane_sum.sv
// Reduces a packed four-lane 16-bit product to its unsigned 18-bit lane sum.
module vecmac_lane_sum
    import vecmac_pkg::*;
(
    input  logic [LANES*PROD_W-1:0] product,
    output logic [SUM_W-1:0]        lane_sum
);

    always_comb begin
        // NOTE: assign a default before the loop so no path leaves the output unassigned and infers a latch.
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + SUM_W'(product[k*PROD_W +: PROD_W]);
        end
    end

endmodule

// File: rtl/vecmac_ctrl.sv
// Dot-product sequencer: issues operand pairs to the 4-lane multiplier and
// accumulates the returned lane sums into a wrapping scalar result.
module vecmac_ctrl
    import vecmac_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W,
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic    clk,
    input  logic    rst_n,
    vecmac_if.slave bus
);

    state_e           state;
    state_e           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] returned;
    logic [LEN_W-1:0] issued_nxt;
    logic [LEN_W-1:0] returned_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [SUM_W-1:0] lane_sum;
    logic             cmd_fire;
    logic             op_fire;
    logic             ret_fire;

    vecmac_lane_sum u_lane_sum (
        .product  (bus.mul_product),
        .lane_sum (lane_sum)
    );

    // Returns only count while a command is live; stale ones after an abort are dropped.
    assign cmd_fire     = (state == ST_IDLE) && bus.cmd_valid;
    assign op_fire      = bus.op_ready && bus.op_valid;
    assign ret_fire     = bus.mul_out_valid && ((state == ST_ISSUE) || (state == ST_DRAIN));
    assign issued_nxt   = issued + LEN_W'(op_fire);
    assign returned_nxt = returned + LEN_W'(ret_fire);

    always_comb begin
        state_nxt = state;
        acc_nxt   = ret_fire ? acc + ACC_W'(lane_sum) : acc;
        if (cmd_fire) begin
            acc_nxt = '0;
        end
        unique case (state)
            ST_IDLE:  if (bus.cmd_valid) state_nxt = (bus.cmd_len == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (op_fire && (issued_nxt == len_q))
                          state_nxt = (returned_nxt == len_q) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (returned_nxt == len_q) state_nxt = ST_DONE;
            ST_DONE:  if (bus.res_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            len_q            <= '0;
            issued           <= '0;
            returned         <= '0;
            acc              <= '0;
            bus.cmd_ready    <= 1'b1;
            bus.op_ready     <= 1'b0;
            bus.mul_in_valid <= 1'b0;
            bus.mul_in_a     <= '0;
            bus.mul_in_b     <= '0;
            bus.res_valid    <= 1'b0;
            bus.res_data     <= '0;
            bus.busy         <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples the values from before this edge.
            state <= state_nxt;
            acc   <= acc_nxt;
            if (cmd_fire) begin
                len_q    <= bus.cmd_len;
                issued   <= '0;
                returned <= '0;
            end else begin
                issued   <= issued_nxt;
                returned <= returned_nxt;
            end
            bus.mul_in_valid <= op_fire;
            if (op_fire) begin
                bus.mul_in_a <= bus.op_a;
                bus.mul_in_b <= bus.op_b;
            end
            bus.cmd_ready <= (state_nxt == ST_IDLE);
            bus.op_ready  <= (state_nxt == ST_ISSUE);
            bus.busy      <= (state_nxt != ST_IDLE);
            bus.res_valid <= (state_nxt == ST_DONE);
            bus.res_data  <= (state_nxt == ST_DONE) ? acc_nxt : '0;
        end
    end

endmodule

// File: tb/tb_vecmac_ctrl.sv
// Bench for vecmac_ctrl: a behavioural multiplier with configurable latency
// feeds products back, and results are compared against a dot-product model.
module tb_vecmac_ctrl;
    import vecmac_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vecmac_if #(.LEN_W(8), .ACC_W(32)) bus   ();
    vecmac_if #(.LEN_W(8), .ACC_W(18)) bus18 ();

    vecmac_ctrl #(.LEN_W(8), .ACC_W(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    vecmac_ctrl #(.LEN_W(8), .ACC_W(18)) dut18 (.clk(clk), .rst_n(rst_n), .bus(bus18));

    typedef struct {
        int unsigned due;
        logic [63:0] p;
    } ret_t;

    ret_t        mq[$];
    ret_t        mq18[$];
    ret_t        rn;
    ret_t        rn18;
    int unsigned cyc         = 0;
    int unsigned last_ret    = 0;
    int unsigned n_issue     = 0;
    int unsigned lat         = 2;
    bit          inject_spur = 1'b0;
    int          errs        = 0;
    int          checks      = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    // External multiplier behaviour: four independent unsigned 8x8 lane products.
    function automatic logic [63:0] mul4(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        for (int k = 0; k < 4; k++) p[16*k +: 16] = 16'(a[8*k +: 8]) * 16'(b[8*k +: 8]);
        return p;
    endfunction

    // Expected result: plain dot product over all int8 lanes, wrapped to acc_w bits.
    function automatic logic [63:0] dot_ref(input int acc_w);
        longint unsigned s;
        s = 0;
        foreach (qa[i])
            for (int k = 0; k < 4; k++)
                s += longint'(qa[i][8*k +: 8]) * longint'(qb[i][8*k +: 8]);
        return s & ((64'd1 << acc_w) - 1);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mul_in_valid === 1'b1) begin
            rn.due = cyc + lat;
            rn.p   = mul4(bus.mul_in_a, bus.mul_in_b);
            mq.push_back(rn);
            n_issue++;
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.mul_out_valid = 1'b1;
            bus.mul_product   = mq[0].p;
            last_ret          = cyc;
            void'(mq.pop_front());
        end else begin
            bus.mul_out_valid = inject_spur;
            bus.mul_product   = {$urandom, $urandom};
        end
    end

    always @(negedge clk) begin
        if (bus18.mul_in_valid === 1'b1) begin
            rn18.due = cyc + 2;
            rn18.p   = mul4(bus18.mul_in_a, bus18.mul_in_b);
            mq18.push_back(rn18);
        end
        if (mq18.size() > 0 && mq18[0].due <= cyc) begin
            bus18.mul_out_valid = 1'b1;
            bus18.mul_product   = mq18[0].p;
            void'(mq18.pop_front());
        end else begin
            bus18.mul_out_valid = 1'b0;
            bus18.mul_product   = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full command on the 32-bit instance; mode 0 = op_valid held, 1 = alternating, 2 = random.
    task automatic run_cmd(input string name, input int len, input int mode, input int hold,
                           input logic [31:0] expv);
        int i;
        int n;
        bit hs;
        bit ph;
        i  = 0;
        n  = 0;
        ph = 1'b1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errs++; $display("FAIL %s cmd_ready_before_accept: got %b want 1", name, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'(len);
        tick();
        bus.cmd_valid = 1'b0;
        if (len == 0) begin
            checks++;
            if ({bus.res_valid, bus.op_ready} !== 2'b10) begin
                errs++; $display("FAIL %s zero_len_res_valid_T+1: got %b want 10", name, {bus.res_valid, bus.op_ready});
            end
        end else begin
            checks++;
            if ({bus.op_ready, bus.busy, bus.cmd_ready} !== 3'b110) begin
                errs++; $display("FAIL %s issue_at_T+1: got %b want 110", name, {bus.op_ready, bus.busy, bus.cmd_ready});
            end
            while (i < len && n < 400) begin
                bus.op_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
                ph           = ~ph;
                bus.op_a     = qa[i];
                bus.op_b     = qb[i];
                hs           = bus.op_valid && bus.op_ready;
                tick();
                n++;
                checks++;
                if (hs) begin
                    if ({bus.mul_in_valid, bus.mul_in_a, bus.mul_in_b} !== {1'b1, qa[i], qb[i]}) begin
                        errs++; $display("FAIL %s issue_%0d: got %b %h %h want 1 %h %h", name, i,
                                         bus.mul_in_valid, bus.mul_in_a, bus.mul_in_b, qa[i], qb[i]);
                    end
                    i++;
                end else if (bus.mul_in_valid !== 1'b0) begin
                    errs++; $display("FAIL %s spurious_mul_in_valid: got %b want 0", name, bus.mul_in_valid);
                end
            end
            bus.op_valid = 1'b0;
            checks++;
            if (i != len) begin
                errs++; $display("FAIL %s issue_timeout: got %0d issued want %0d", name, i, len);
            end
            n = 0;
            while (bus.res_valid !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            checks++;
            if (bus.res_valid !== 1'b1) begin
                errs++; $display("FAIL %s result_timeout: got res_valid %b want 1", name, bus.res_valid);
            end else begin
                checks++;
                if (cyc !== last_ret + 1) begin
                    errs++; $display("FAIL %s result_latency: got cycle %0d want %0d", name, cyc, last_ret + 1);
                end
            end
        end
        checks++;
        if (bus.res_data !== expv) begin
            errs++; $display("FAIL %s res_data: got %h want %h", name, bus.res_data, expv);
        end
        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_len   = 8'd3;
            inject_spur   = 1'b1;
            tick();
            checks++;
            if ({bus.res_valid, bus.cmd_ready, bus.res_data} !== {2'b10, expv}) begin
                errs++; $display("FAIL %s hold_%0d: got %b %b %h want 1 0 %h", name, h,
                                 bus.res_valid, bus.cmd_ready, bus.res_data, expv);
            end
        end
        bus.cmd_valid = 1'b0;
        inject_spur   = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if ({bus.cmd_ready, bus.res_valid, bus.busy} !== 3'b100) begin
            errs++; $display("FAIL %s back_to_idle: got %b want 100", name, {bus.cmd_ready, bus.res_valid, bus.busy});
        end
    endtask

    task automatic fill_random(input int len);
        qa.delete();
        qb.delete();
        for (int i = 0; i < len; i++) begin
            qa.push_back($urandom);
            qb.push_back($urandom);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.cmd_ready, bus.op_ready, bus.mul_in_valid, bus.res_valid, bus.busy,
             bus.mul_in_a, bus.mul_in_b, bus.res_data} !== {5'b10000, 96'd0}) begin
            errs++; $display("FAIL reset_values: got %b %h %h %h want 10000 0 0 0",
                             {bus.cmd_ready, bus.op_ready, bus.mul_in_valid, bus.res_valid, bus.busy},
                             bus.mul_in_a, bus.mul_in_b, bus.res_data);
        end
        checks++;
        if ({bus18.cmd_ready, bus18.op_ready, bus18.res_valid, bus18.busy, bus18.res_data} !== {4'b1000, 18'd0}) begin
            errs++; $display("FAIL reset_values_acc18: got %b %h want 1000 0",
                             {bus18.cmd_ready, bus18.op_ready, bus18.res_valid, bus18.busy}, bus18.res_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        lat = 3;
        qa = {32'hFFFF_FFFF};
        qb = {32'hFFFF_FFFF};
        run_cmd("single", 1, 0, 0, 32'h0003_F804);
    endtask

    task automatic test_pair();
        lat = 2;
        qa = {32'h1234_5678, 32'h0000_00FF};
        qb = {32'h8765_4321, 32'h0000_00FF};
        run_cmd("pair", 2, 0, 0, 32'h0001_41FD);
    endtask

    task automatic test_zero_len();
        int unsigned n0;
        n0 = n_issue;
        qa.delete();
        qb.delete();
        run_cmd("zero_len", 0, 0, 0, 32'h0);
        repeat (3) tick();
        checks++;
        if (n_issue !== n0) begin
            errs++; $display("FAIL zero_len_no_issue: got %0d issues want 0", n_issue - n0);
        end
    endtask

    task automatic test_wrap18();
        int  i;
        int  n;
        bit  hs;
        bit  ph;
        for (int m = 0; m < 2; m++) begin
            i  = 0;
            n  = 0;
            ph = 1'b1;
            bus18.cmd_valid = 1'b1;
            bus18.cmd_len   = 8'd2;
            tick();
            bus18.cmd_valid = 1'b0;
            while (i < 2 && n < 50) begin
                bus18.op_valid = (m == 0) ? 1'b1 : ph;
                ph             = ~ph;
                bus18.op_a     = 32'hFFFF_FFFF;
                bus18.op_b     = 32'hFFFF_FFFF;
                hs             = bus18.op_valid && bus18.op_ready;
                tick();
                n++;
                checks++;
                if (bus18.mul_in_valid !== hs) begin
                    errs++; $display("FAIL wrap18_mode%0d_issue: got %b want %b", m, bus18.mul_in_valid, hs);
                end
                if (hs) i++;
            end
            bus18.op_valid = 1'b0;
            n = 0;
            while (bus18.res_valid !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            checks++;
            if ({bus18.res_valid, bus18.res_data} !== {1'b1, 18'h3F008}) begin
                errs++; $display("FAIL wrap18_mode%0d_result: got %b %h want 1 3f008", m, bus18.res_valid, bus18.res_data);
            end
            bus18.res_ready = 1'b1;
            tick();
            bus18.res_ready = 1'b0;
            checks++;
            if (bus18.cmd_ready !== 1'b1) begin
                errs++; $display("FAIL wrap18_mode%0d_idle: got %b want 1", m, bus18.cmd_ready);
            end
        end
    endtask

    task automatic test_hold();
        lat = 4;
        fill_random(3);
        run_cmd("hold", 3, 1, 5, 32'(dot_ref(32)));
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 3; t++) begin
            lat = 1 + t;
            fill_random(2 + t);
            run_cmd("back_to_back", 2 + t, 0, 0, 32'(dot_ref(32)));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        lat = 3;
        fill_random(4);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd4;
        tick();
        bus.cmd_valid = 1'b0;
        bus.op_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.op_a = qa[i];
            bus.op_b = qb[i];
            tick();
        end
        bus.op_valid = 1'b0;
        n = 0;
        while (mq.size() != 2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if ({mq.size() == 2, bus.op_ready, bus.busy} !== 3'b101) begin
            errs++; $display("FAIL reset_mid_drain: got outstanding %0d op_ready %b busy %b want 2 0 1",
                             mq.size(), bus.op_ready, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.op_ready, bus.mul_in_valid, bus.res_valid, bus.busy,
             bus.mul_in_a, bus.mul_in_b, bus.res_data} !== {5'b10000, 96'd0}) begin
            errs++; $display("FAIL reset_mid_values: got %b %h %h %h want 10000 0 0 0",
                             {bus.cmd_ready, bus.op_ready, bus.mul_in_valid, bus.res_valid, bus.busy},
                             bus.mul_in_a, bus.mul_in_b, bus.res_data);
        end
        #1;
        rst_n = 1'b1;
        n = 0;
        while (mq.size() > 0 && n < 20) begin
            tick();
            n++;
            checks++;
            if ({bus.cmd_ready, bus.busy, bus.res_valid} !== 3'b100) begin
                errs++; $display("FAIL reset_mid_late_return: got %b want 100", {bus.cmd_ready, bus.busy, bus.res_valid});
            end
        end
        tick();
        qa = {32'h0000_00FF};
        qb = {32'h0000_00FF};
        run_cmd("after_reset", 1, 0, 0, 32'h0000_FE01);
    endtask

    task automatic test_random();
        int len;
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(0, 12);
            lat = $urandom_range(1, 5);
            fill_random(len);
            run_cmd("random", len, $urandom_range(0, 2), $urandom_range(0, 3), 32'(dot_ref(32)));
        end
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_len     = '0;
        bus.op_valid    = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.res_ready   = 1'b0;
        bus18.cmd_valid = 1'b0;
        bus18.cmd_len   = '0;
        bus18.op_valid  = 1'b0;
        bus18.op_a      = '0;
        bus18.op_b      = '0;
        bus18.res_ready = 1'b0;

        test_reset();
        test_single();
        test_pair();
        test_zero_len();
        test_wrap18();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
